// File: rtl/multicycle_ctrl.sv
// Main control FSM for a multi-cycle RV32I datapath.
// State-decoded strobes are gated low combinationally while reset is asserted.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [2:0] immSrc,
  output logic       illegal,
  output logic [3:0] state
);

  localparam int unsigned STATE_W = 4;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_JALR_ADR = 4'd11;
  localparam logic [3:0] S_JALR_JMP = 4'd12;
  localparam logic [3:0] S_LUI      = 4'd13;
  localparam logic [3:0] S_AUIPC    = 4'd14;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic [STATE_W-1:0] state_q, state_d;
  logic mem_req_c, mem_write_c, ir_write_c, pc_write_c, reg_write_c, illegal_c;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Immediate format follows the opcode regardless of state.
  always_comb begin
    immSrc = 3'b000;
    case (op)
      OP_BRANCH:          immSrc = 3'b001;
      OP_STORE:           immSrc = 3'b010;
      OP_JAL:             immSrc = 3'b011;
      OP_LUI, OP_AUIPC:   immSrc = 3'b100;
      default:            immSrc = 3'b000;
    endcase
  end

  always_comb begin
    state_d     = S_FETCH;
    mem_req_c   = 1'b0;
    AdrSrc      = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    reg_write_c = 1'b0;
    illegal_c   = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_req_c  = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        ir_write_c = mem_ready;
        pc_write_c = mem_ready;
        state_d    = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECUTER;
          OP_ITYPE:          state_d = S_EXECUTEI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR_ADR;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_AUIPC;
          default: begin
            state_d   = S_FETCH;
            illegal_c = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req_c = 1'b1;
        AdrSrc    = 1'b1;
        state_d   = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        ResultSrc   = 2'b01;
        reg_write_c = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req_c   = 1'b1;
        AdrSrc      = 1'b1;
        mem_write_c = 1'b1;
        state_d     = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTER, S_EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = (state_q == S_EXECUTEI) ? 2'b01 : 2'b00;
        ALUOp   = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: reg_write_c = 1'b1;
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUOp      = 2'b01;
        pc_write_c = branch_taken;
      end
      // JAL and JALR_JMP redirect PC from ALUOut and compute the link in the same cycle.
      S_JAL, S_JALR_JMP: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        pc_write_c = 1'b1;
        state_d    = S_ALUWB;
      end
      S_JALR_ADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = S_JALR_JMP;
      end
      S_LUI, S_AUIPC: begin
        ALUSrcA = (state_q == S_LUI) ? 2'b11 : 2'b01;
        ALUSrcB = 2'b01;
        state_d = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign mem_req  = mem_req_c   & ~reset;
  assign MemWrite = mem_write_c & ~reset;
  assign IRWrite  = ir_write_c  & ~reset;
  assign PCWrite  = pc_write_c  & ~reset;
  assign RegWrite = reg_write_c & ~reset;
  assign illegal  = illegal_c   & ~reset;
  assign state    = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: latency table, instruction-path model
// with random memory waits, and reset-during-wait sequences.
module tb_multicycle_ctrl;

  localparam int ST_FETCH = 0, ST_DECODE = 1, ST_MEMADR = 2, ST_MEMREAD = 3, ST_MEMWB = 4;
  localparam int ST_MEMWRITE = 5, ST_EXECUTER = 6, ST_EXECUTEI = 7, ST_ALUWB = 8, ST_BRANCH = 9;
  localparam int ST_JAL = 10, ST_JALR_ADR = 11, ST_JALR_JMP = 12, ST_LUI = 13, ST_AUIPC = 14;

  typedef struct packed {
    logic       mem_req;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       PCWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [2:0] immSrc;
    logic       illegal;
  } ctrl_t;

  typedef struct {
    logic [6:0] op;
    logic       bt;
    int         lat;
    int         pcw;
    int         rw;
    int         mw;
    int         ill;
  } vec_t;

  typedef struct {
    int   st;
    logic mr;
  } entry_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic       branch_taken;
  logic       mem_ready;
  logic       mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [2:0] immSrc;
  logic [3:0] state;

  int n_checks = 0;
  int n_errors = 0;
  entry_t seq_q[$];
  vec_t vecs[12];
  logic [6:0] legal_ops[10];

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .branch_taken(branch_taken), .mem_ready(mem_ready),
    .mem_req(mem_req), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .immSrc(immSrc), .illegal(illegal), .state(state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic ctrl_t dut_ctrl();
    ctrl_t c;
    c = '{mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite,
          ResultSrc, ALUSrcA, ALUSrcB, ALUOp, immSrc, illegal};
    return c;
  endfunction

  function automatic bit is_legal(input logic [6:0] o);
    foreach (legal_ops[i]) if (legal_ops[i] == o) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [2:0] exp_imm(input logic [6:0] o);
    if (o == 7'b1100011) return 3'b001;
    if (o == 7'b0100011) return 3'b010;
    if (o == 7'b1101111) return 3'b011;
    if (o == 7'b0110111 || o == 7'b0010111) return 3'b100;
    return 3'b000;
  endfunction

  // Control word each state must present, straight from the per-state output table.
  function automatic ctrl_t exp_ctrl(input int st, input logic mr, input logic [6:0] o, input logic bt);
    ctrl_t c;
    c = '0;
    c.immSrc = exp_imm(o);
    case (st)
      ST_FETCH:    begin c.mem_req = 1; c.ALUSrcB = 2; c.ResultSrc = 2; c.IRWrite = mr; c.PCWrite = mr; end
      ST_DECODE:   begin c.ALUSrcA = 1; c.ALUSrcB = 1; c.illegal = !is_legal(o); end
      ST_MEMADR:   begin c.ALUSrcA = 2; c.ALUSrcB = 1; end
      ST_MEMREAD:  begin c.mem_req = 1; c.AdrSrc = 1; end
      ST_MEMWB:    begin c.ResultSrc = 1; c.RegWrite = 1; end
      ST_MEMWRITE: begin c.mem_req = 1; c.AdrSrc = 1; c.MemWrite = 1; end
      ST_EXECUTER: begin c.ALUSrcA = 2; c.ALUSrcB = 0; c.ALUOp = 2; end
      ST_EXECUTEI: begin c.ALUSrcA = 2; c.ALUSrcB = 1; c.ALUOp = 2; end
      ST_ALUWB:    c.RegWrite = 1;
      ST_BRANCH:   begin c.ALUSrcA = 2; c.ALUOp = 1; c.PCWrite = bt; end
      ST_JAL:      begin c.ALUSrcA = 1; c.ALUSrcB = 2; c.PCWrite = 1; end
      ST_JALR_ADR: begin c.ALUSrcA = 2; c.ALUSrcB = 1; end
      ST_JALR_JMP: begin c.ALUSrcA = 1; c.ALUSrcB = 2; c.PCWrite = 1; end
      ST_LUI:      begin c.ALUSrcA = 3; c.ALUSrcB = 1; end
      ST_AUIPC:    begin c.ALUSrcA = 1; c.ALUSrcB = 1; end
      default:     c = '0;
    endcase
    return c;
  endfunction

  task automatic push(input int st, input logic mr);
    entry_t e;
    e.st = st;
    e.mr = mr;
    seq_q.push_back(e);
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected instruction path: fw/mw stall cycles before the fetch and data access complete.
  task automatic build_seq(input logic [6:0] o, input int fw, input int mw);
    seq_q.delete();
    for (int i = 0; i < fw; i++) push(ST_FETCH, 1'b0);
    push(ST_FETCH, 1'b1);
    push(ST_DECODE, rbit());
    case (o)
      7'b0000011: begin
        push(ST_MEMADR, rbit());
        for (int i = 0; i < mw; i++) push(ST_MEMREAD, 1'b0);
        push(ST_MEMREAD, 1'b1);
        push(ST_MEMWB, rbit());
      end
      7'b0100011: begin
        push(ST_MEMADR, rbit());
        for (int i = 0; i < mw; i++) push(ST_MEMWRITE, 1'b0);
        push(ST_MEMWRITE, 1'b1);
      end
      7'b0110011: begin push(ST_EXECUTER, rbit()); push(ST_ALUWB, rbit()); end
      7'b0010011: begin push(ST_EXECUTEI, rbit()); push(ST_ALUWB, rbit()); end
      7'b1100011: push(ST_BRANCH, rbit());
      7'b1101111: begin push(ST_JAL, rbit()); push(ST_ALUWB, rbit()); end
      7'b1100111: begin push(ST_JALR_ADR, rbit()); push(ST_JALR_JMP, rbit()); push(ST_ALUWB, rbit()); end
      7'b0110111: begin push(ST_LUI, rbit()); push(ST_ALUWB, rbit()); end
      7'b0010111: begin push(ST_AUIPC, rbit()); push(ST_ALUWB, rbit()); end
      default: ;
    endcase
  endtask

  // Called just after a rising edge with the DUT in FETCH; returns the same way.
  task automatic run_seq(input logic [6:0] o, input logic bt);
    op = o;
    branch_taken = bt;
    for (int i = 0; i < seq_q.size(); i++) begin
      mem_ready = seq_q[i].mr;
      @(negedge clk);
      check("state", 32'(state), 32'(seq_q[i].st));
      check("ctrl", 32'(dut_ctrl()), 32'(exp_ctrl(seq_q[i].st, seq_q[i].mr, o, bt)));
      @(posedge clk);
      #1;
    end
    check("end_state", 32'(state), 32'(ST_FETCH));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    legal_ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                  7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0010011};
    //           op            bt  lat pcw rw mw ill
    vecs[0]  = '{7'b0110011, 1'b0, 4, 1, 1, 0, 0};
    vecs[1]  = '{7'b0010011, 1'b0, 4, 1, 1, 0, 0};
    vecs[2]  = '{7'b0000011, 1'b0, 5, 1, 1, 0, 0};
    vecs[3]  = '{7'b0100011, 1'b0, 4, 1, 0, 1, 0};
    vecs[4]  = '{7'b1100011, 1'b0, 3, 1, 0, 0, 0};
    vecs[5]  = '{7'b1100011, 1'b1, 3, 2, 0, 0, 0};
    vecs[6]  = '{7'b1101111, 1'b0, 4, 2, 1, 0, 0};
    vecs[7]  = '{7'b1100111, 1'b0, 5, 2, 1, 0, 0};
    vecs[8]  = '{7'b0110111, 1'b0, 4, 1, 1, 0, 0};
    vecs[9]  = '{7'b0010111, 1'b0, 4, 1, 1, 0, 0};
    vecs[10] = '{7'b1111111, 1'b0, 2, 1, 0, 0, 1};
    vecs[11] = '{7'b0000000, 1'b1, 2, 1, 0, 0, 1};

    reset = 1'b1;
    op = 7'b0110011;
    branch_taken = 1'b1;
    mem_ready = 1'b1;

    // Strobes must stay low during reset even though FETCH would otherwise fire them.
    repeat (2) begin
      @(negedge clk);
      check("rst_strobes", 32'({mem_req, MemWrite, IRWrite, PCWrite, RegWrite, illegal}), 32'(0));
    end
    @(posedge clk);
    #1;
    check("rst_state", 32'(state), 32'(ST_FETCH));
    reset = 1'b0;

    // Latency and strobe counts with memory always ready.
    for (int v = 0; v < 12; v++) begin
      int cyc, pcw, rw, mw, ill;
      cyc = 0; pcw = 0; rw = 0; mw = 0; ill = 0;
      op = vecs[v].op;
      branch_taken = vecs[v].bt;
      mem_ready = 1'b1;
      do begin
        @(negedge clk);
        pcw += int'(PCWrite);
        rw  += int'(RegWrite);
        mw  += int'(MemWrite);
        ill += int'(illegal);
        cyc++;
        @(posedge clk);
        #1;
      end while (state != 4'(ST_FETCH) && cyc < 20);
      check($sformatf("lat[%0d]", v), 32'(cyc), 32'(vecs[v].lat));
      check($sformatf("pcw[%0d]", v), 32'(pcw), 32'(vecs[v].pcw));
      check($sformatf("rw[%0d]", v), 32'(rw), 32'(vecs[v].rw));
      check($sformatf("mw[%0d]", v), 32'(mw), 32'(vecs[v].mw));
      check($sformatf("ill[%0d]", v), 32'(ill), 32'(vecs[v].ill));
      if (state != 4'(ST_FETCH)) do_reset();
    end

    // Load with two MEMREAD stalls: 0,1,2,3,3,3,4,0.
    build_seq(7'b0000011, 0, 2);
    run_seq(7'b0000011, 1'b0);
    // Branch not taken then taken; JALR; illegal opcode.
    build_seq(7'b1100011, 0, 0);
    run_seq(7'b1100011, 1'b0);
    build_seq(7'b1100011, 0, 0);
    run_seq(7'b1100011, 1'b1);
    build_seq(7'b1100111, 0, 0);
    run_seq(7'b1100111, 1'b0);
    build_seq(7'b1111111, 1, 0);
    run_seq(7'b1111111, 1'b0);

    // Reset asserted mid-stall in MEMREAD and MEMWRITE.
    for (int k = 0; k < 2; k++) begin
      logic [6:0] o;
      int wait_st;
      o = (k == 0) ? 7'b0000011 : 7'b0100011;
      wait_st = (k == 0) ? ST_MEMREAD : ST_MEMWRITE;
      op = o;
      mem_ready = 1'b1;
      repeat (3) begin
        @(posedge clk);
        #1;
      end
      mem_ready = 1'b0;
      @(negedge clk);
      check("wait_state", 32'(state), 32'(wait_st));
      check("wait_memwrite", 32'(MemWrite), 32'(k));
      reset = 1'b1;
      #1;
      check("rst_mid_memwrite", 32'(MemWrite), 32'(0));
      check("rst_mid_memreq", 32'(mem_req), 32'(0));
      @(posedge clk);
      #1;
      check("rst_mid_state", 32'(state), 32'(ST_FETCH));
      reset = 1'b0;
      mem_ready = 1'b1;
      @(negedge clk);
      check("post_rst_ctrl", 32'(dut_ctrl()), 32'(exp_ctrl(ST_FETCH, 1'b1, o, branch_taken)));
      @(posedge clk);
      #1;
      // Drain the fetched instruction so the next one starts from FETCH.
      while (state != 4'(ST_FETCH)) begin
        @(posedge clk);
        #1;
      end
    end

    // Random instruction stream with random memory stalls.
    for (int n = 0; n < 250; n++) begin
      logic [6:0] o;
      logic bt;
      if ($urandom_range(0, 3) == 0) o = 7'($urandom_range(0, 127));
      else o = legal_ops[$urandom_range(0, 9)];
      bt = rbit();
      build_seq(o, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
      run_seq(o, bt);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
